// File: rtl/nn_layer_mac_pkg.sv
// Shared definitions for the nn_layer_mac block: FSM state encoding,
// activation selector constants and the output saturation helper.
package nn_layer_mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_BIAS = 3'd2,
    S_ACT  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int unsigned ACT_IDENTITY = 0;
  localparam int unsigned ACT_RELU     = 1;

  // Width of the intermediate used by saturate(); callers sign-extend into it.
  localparam int unsigned SAT_W = 64;

  // Clamp a signed value into the range of a dw-bit signed number.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_layer_mac_mac_unit.sv
// nn_mac_unit: registered multiply / arithmetic-shift / accumulate datapath.
// Ports: clk, rst (sync, active-high), clr_i (zero acc, highest priority),
//        mac_en_i (acc += (w*x)>>>FRAC), bias_en_i (acc += sign-extended b),
//        w_i/x_i/b_i signed operands, acc_o registered signed accumulator.
module nn_mac_unit
  import nn_layer_mac_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned FRAC = 4,
  parameter int unsigned AW   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 mac_en_i,
  input  logic                 bias_en_i,
  input  logic signed [DW-1:0] w_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [AW-1:0] acc_o
);

  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] term_c;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;

  // Full-width signed product, rescaled by an arithmetic (flooring) shift.
  always_comb begin
    prod_c = PW'(w_i) * PW'(x_i);
    term_c = prod_c >>> FRAC;
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + AW'(term_c);
    end else if (bias_en_i) begin
      acc_d = acc_q + AW'(b_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/nn_layer_mac.sv
// nn_layer_mac: sequential fully-connected layer, one MAC per cycle.
// Ports: clk, rst (sync, active-high), req (start, sampled in IDLE),
//        x_in (packed signed inputs), cfg_we/cfg_addr/cfg_data (weight and
//        bias writes, honoured only while idle), busy (not IDLE),
//        ack_layer (one-cycle done pulse), y_out (packed signed results).
module nn_layer_mac
  import nn_layer_mac_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned DW    = 8,
  parameter int unsigned FRAC  = 4,
  parameter int unsigned ACT   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req,
  input  logic [N_IN*DW-1:0]                     x_in,
  input  logic                                   cfg_we,
  input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]    cfg_addr,
  input  logic [DW-1:0]                          cfg_data,
  output logic                                   busy,
  output logic                                   ack_layer,
  output logic [N_OUT*DW-1:0]                    y_out
);

  localparam int unsigned NW = N_IN * N_OUT;
  localparam int unsigned AW = 2 * DW + $clog2(N_IN + 1);
  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [JW-1:0]        j_q, j_d;
  logic [N_IN*DW-1:0]   x_q, x_d;
  logic [N_OUT*DW-1:0]  y_q, y_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic signed [DW-1:0] w_q [NW];
  logic signed [DW-1:0] b_q [N_OUT];

  logic signed [DW-1:0] w_sel_c, x_sel_c, b_sel_c;
  logic signed [DW-1:0] sat_c, act_c;
  logic signed [AW-1:0] acc_c;
  logic                 mac_clr_c, mac_en_c, bias_en_c;
  logic                 cfg_ok_c;

  // Operand selection for the current (neuron j, input i) step.
  always_comb begin
    w_sel_c = '0;
    x_sel_c = '0;
    b_sel_c = '0;
    for (int k = 0; k < int'(NW); k++) begin
      if (k == int'(j_q) * int'(N_IN) + int'(i_q)) w_sel_c = w_q[k];
    end
    for (int k = 0; k < int'(N_IN); k++) begin
      if (k == int'(i_q)) x_sel_c = x_q[k*DW +: DW];
    end
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (k == int'(j_q)) b_sel_c = b_q[k];
    end
  end

  // Saturate the accumulator, then optionally clip negatives to zero.
  always_comb begin
    sat_c = DW'(saturate(SAT_W'(acc_c), DW));
    act_c = sat_c;
    if (ACT == ACT_RELU && sat_c[DW-1]) act_c = '0;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    x_d       = x_q;
    y_d       = y_q;
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    bias_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          x_d       = x_in;
          i_d       = '0;
          j_d       = '0;
          mac_clr_c = 1'b1;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        mac_en_c = 1'b1;
        if (32'(i_q) < N_IN - 1) begin
          i_d = i_q + IW'(1);
        end else begin
          state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        bias_en_c = 1'b1;
        state_d   = S_ACT;
      end
      S_ACT: begin
        for (int k = 0; k < int'(N_OUT); k++) begin
          if (k == int'(j_q)) y_d[k*DW +: DW] = act_c;
        end
        if (32'(j_q) == N_OUT - 1) begin
          state_d = S_DONE;
        end else begin
          j_d       = j_q + JW'(1);
          i_d       = '0;
          mac_clr_c = 1'b1;
          state_d   = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // ack is the registered image of DONE, so it lands in the following IDLE cycle.
    ack_d  = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Parameter store; out-of-range addresses match no entry and are ignored.
  assign cfg_ok_c = cfg_we && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NW); k++) w_q[k] <= '0;
      for (int k = 0; k < int'(N_OUT); k++) b_q[k] <= '0;
    end else if (cfg_ok_c) begin
      for (int k = 0; k < int'(NW); k++) begin
        if (32'(cfg_addr) == 32'(k)) w_q[k] <= cfg_data;
      end
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (32'(cfg_addr) == NW + 32'(k)) b_q[k] <= cfg_data;
      end
    end
  end

  nn_mac_unit #(
    .DW   (DW),
    .FRAC (FRAC),
    .AW   (AW)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (mac_clr_c),
    .mac_en_i  (mac_en_c),
    .bias_en_i (bias_en_c),
    .w_i       (w_sel_c),
    .x_i       (x_sel_c),
    .b_i       (b_sel_c),
    .acc_o     (acc_c)
  );

  assign busy      = busy_q;
  assign ack_layer = ack_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_nn_layer_mac.sv
// Scoreboard bench: two instances (identity and ReLU) share all inputs; the
// stimulus side pushes expected results, a monitor pops them on ack_layer.
module tb_nn_layer_mac;

  localparam int unsigned N_IN   = 3;
  localparam int unsigned N_OUT  = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned FRAC   = 4;
  localparam int unsigned XW     = N_IN * DW;
  localparam int unsigned YW     = N_OUT * DW;
  localparam int unsigned NW     = N_IN * N_OUT;
  localparam int unsigned CAW    = $clog2(NW + N_OUT);
  localparam int          LAT    = N_OUT * (N_IN + 2) + 1;
  localparam int          PERIOD = LAT + 1;

  logic           clk;
  logic           rst;
  logic           req;
  logic [XW-1:0]  x_in;
  logic           cfg_we;
  logic [CAW-1:0] cfg_addr;
  logic [DW-1:0]  cfg_data;
  logic           busy_id, ack_id, busy_re, ack_re;
  logic [YW-1:0]  y_id, y_re;

  nn_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT(0)) dut_id (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy_id),
    .ack_layer(ack_id), .y_out(y_id)
  );

  nn_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT(1)) dut_re (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy_re),
    .ack_layer(ack_re), .y_out(y_re)
  );

  typedef struct {
    logic [YW-1:0] y_id;
    logic [YW-1:0] y_re;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   acks_seen  = 0;
  int   ops_issued = 0;
  int   w_m [NW];
  int   b_m [N_OUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^FRAC, i.e. the arithmetic right shift of the product.
  function automatic int fdiv(input int p);
    int d;
    d = 1 << FRAC;
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  function automatic logic [XW-1:0] pack3(input int a, input int b, input int c);
    logic [XW-1:0] r;
    r = {DW'(c), DW'(b), DW'(a)};
    return r;
  endfunction

  function automatic void model_cfg(input int addr, input int data);
    if (addr < int'(NW)) w_m[addr] = data;
    else if (addr < int'(NW + N_OUT)) b_m[addr - int'(NW)] = data;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < int'(NW); k++) w_m[k] = 0;
    for (int k = 0; k < int'(N_OUT); k++) b_m[k] = 0;
  endfunction

  function automatic void model_expect(input logic [XW-1:0] x, output logic [YW-1:0] yi,
                                       output logic [YW-1:0] yr);
    int acc, v, hi, lo;
    logic signed [DW-1:0] t;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    yi = '0;
    yr = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      acc = 0;
      for (int i = 0; i < int'(N_IN); i++) begin
        t = x[i*DW +: DW];
        acc += fdiv(w_m[j*int'(N_IN) + i] * int'(t));
      end
      acc += b_m[j];
      v = (acc > hi) ? hi : ((acc < lo) ? lo : acc);
      yi[j*DW +: DW] = DW'(v);
      yr[j*DW +: DW] = (v < 0) ? DW'(0) : DW'(v);
    end
  endfunction

  // Monitor: every ack pops one expectation and checks data and latency.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (ack_id || ack_re) begin
      acks_seen++;
      check("ack_agree", 64'(ack_re), 64'(ack_id));
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("y_identity", 64'(y_id), 64'(e.y_id));
        check("y_relu", 64'(y_re), 64'(e.y_re));
        check("ack_latency", 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
  end

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = CAW'(addr);
    cfg_data = DW'(data);
    model_cfg(addr, data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_op(input logic [XW-1:0] x, input bit cfg_en, input int addr,
                          input int data, input bit use_const,
                          input logic [YW-1:0] c_id, input logic [YW-1:0] c_re);
    exp_t e;
    logic [YW-1:0] mi, mr;
    @(negedge clk);
    req  = 1'b1;
    x_in = x;
    if (cfg_en) begin
      cfg_we   = 1'b1;
      cfg_addr = CAW'(addr);
      cfg_data = DW'(data);
      model_cfg(addr, data);
    end
    model_expect(x, mi, mr);
    e.y_id    = use_const ? c_id : mi;
    e.y_re    = use_const ? c_re : mr;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    ops_issued++;
    @(negedge clk);
    req    = 1'b0;
    cfg_we = 1'b0;
    check("busy_id_running", 64'(busy_id), 64'(1));
    check("busy_re_running", 64'(busy_re), 64'(1));
  endtask

  task automatic wait_acks();
    int n;
    n = 0;
    while (acks_seen < ops_issued && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ack_timeout", 64'(acks_seen >= ops_issued), 64'(1));
    if (acks_seen < ops_issued) begin
      acks_seen = ops_issued;
      sb.delete();
    end
  endtask

  task automatic random_cfg();
    for (int a = 0; a < int'(NW + N_OUT); a++) begin
      cfg_write(a, int'($urandom_range(0, 255)) - 128);
    end
  endtask

  function automatic logic [XW-1:0] rand_x();
    return pack3(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [XW-1:0] xv;
    logic [YW-1:0] mi, mr;
    exp_t e;
    int base;
    rst = 1'b1; req = 1'b0; x_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy_id", 64'(busy_id), 64'(0));
    check("rst_ack_id", 64'(ack_id), 64'(0));
    check("rst_y_id", 64'(y_id), 64'(0));
    check("rst_busy_re", 64'(busy_re), 64'(0));
    check("rst_ack_re", 64'(ack_re), 64'(0));
    check("rst_y_re", 64'(y_re), 64'(0));
    rst = 1'b0;

    // Weights are zero after reset.
    start_op(pack3(16, 16, 16), 0, 0, 0, 1, '0, '0);
    wait_acks();

    // Basic product, positive and negative saturation.
    cfg_write(0, -79);  cfg_write(1, 32);   cfg_write(2, 0);
    cfg_write(3, 127);  cfg_write(4, 127);  cfg_write(5, 0);
    cfg_write(6, -128); cfg_write(7, -128); cfg_write(8, 0);
    start_op(pack3(16, 16, 0), 0, 0, 0, 1, pack3(-47, 127, -128), pack3(0, 127, 0));
    wait_acks();
    start_op(pack3(127, 127, 0), 0, 0, 0, 0, '0, '0);
    wait_acks();

    // Multi-input neurons with bias; b2 written in the same cycle as req.
    cfg_write(0, 16);  cfg_write(1, 16); cfg_write(2, 16);
    cfg_write(3, -16); cfg_write(4, 0);  cfg_write(5, 16);
    cfg_write(6, 0);   cfg_write(7, 0);  cfg_write(8, 0);
    cfg_write(9, 1);   cfg_write(10, 2);
    xv = pack3(16, 32, 48);
    start_op(xv, 1, 11, -5, 1, pack3(97, 34, -5), pack3(97, 34, 0));
    wait_acks();

    // A write while busy is dropped; the same write while idle lands.
    start_op(xv, 0, 0, 0, 1, pack3(97, 34, -5), pack3(97, 34, 0));
    repeat (2) @(negedge clk);
    cfg_we = 1'b1; cfg_addr = CAW'(0); cfg_data = DW'(100);
    @(negedge clk);
    cfg_we = 1'b0;
    wait_acks();
    cfg_write(0, 100);
    start_op(xv, 0, 0, 0, 1, pack3(127, 34, -5), pack3(127, 34, 0));
    wait_acks();

    // Out-of-range addresses change nothing.
    cfg_write(12, 77);
    cfg_write(15, -3);
    start_op(xv, 0, 0, 0, 1, pack3(127, 34, -5), pack3(127, 34, 0));
    wait_acks();

    // Reset in the second MAC cycle aborts with no ack and clears state.
    start_op(xv, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    ops_issued--;
    @(posedge clk);
    #1;
    check("abort_busy_id", 64'(busy_id), 64'(0));
    check("abort_ack_id", 64'(ack_id), 64'(0));
    check("abort_y_id", 64'(y_id), 64'(0));
    check("abort_busy_re", 64'(busy_re), 64'(0));
    check("abort_y_re", 64'(y_re), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (20) @(negedge clk);
    start_op(xv, 0, 0, 0, 1, '0, '0);
    wait_acks();

    // req held high: back-to-back runs, one ack per PERIOD cycles.
    random_cfg();
    xv = rand_x();
    @(negedge clk);
    req  = 1'b1;
    x_in = xv;
    model_expect(xv, mi, mr);
    base = cyc + 1;
    for (int n = 0; n < 3; n++) begin
      e.y_id = mi; e.y_re = mr; e.acc_cyc = base + n * PERIOD;
      sb.push_back(e);
    end
    ops_issued += 3;
    wait_acks();
    req = 1'b0;
    repeat (PERIOD + 4) @(negedge clk);

    // Randomized configurations and inputs.
    for (int r = 0; r < 15; r++) begin
      if (r % 3 == 0) random_cfg();
      else cfg_write(int'($urandom_range(0, NW + N_OUT - 1)), int'($urandom_range(0, 255)) - 128);
      start_op(rand_x(), (r % 4 == 1), int'($urandom_range(0, NW + N_OUT - 1)),
               int'($urandom_range(0, 255)) - 128, 0, '0, '0);
      wait_acks();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
